// File: rtl/zorro2_autoconfig.sv
// Zorro II autoconfig responder for a 4/8 MB RAM board.
// Define AUTOCONFIG_SHUTUP_EN to let the host shut the board up.
module zorro2_autoconfig #(
   parameter logic [15:0] MANUFACTURER = 16'h0000,
   parameter logic [7:0]  PRODUCT      = 8'h00,
   parameter logic [31:0] SERIAL       = 32'h00000000
) (
   input  logic        CLK,
   input  logic        RESET_n,
   input  logic [23:1] A,
   input  logic        RW_n,
   input  logic        AS_n,
   input  logic        UDS_n,
   input  logic [3:0]  D_IN,
   output logic [3:0]  D_OUT,
   output logic        D_OE,
   input  logic        CFGIN_n,
   output logic        CFGOUT_n,
   input  logic        JP4,
   output logic [2:0]  BASE_RAM,
   output logic        RAM_CONFIGURED_n
);

`ifdef AUTOCONFIG_SHUTUP_EN
   typedef enum logic [1:0] {
      UNCONFIG   = 2'd0,
      CONFIGURED = 2'd1,
      SHUTUP     = 2'd2
   } state_t;
   localparam logic [7:0] FLAGS = 8'h00;
`else
   typedef enum logic [1:0] {
      UNCONFIG   = 2'd0,
      CONFIGURED = 2'd1
   } state_t;
   localparam logic [7:0] FLAGS = 8'h40;
`endif

   state_t      r_state;
   state_t      w_state_nx;
   logic        w_base_ld;

   logic        r_as_m, r_as_s;
   logic        r_uds_m, r_uds_s;
   logic        r_arm;
   logic        r_doe;
   logic [3:0]  r_dout;
   logic [2:0]  r_base;
   logic        r_ramcfg_n;
   logic        r_cfgout_n;

   logic        w_sel;
   logic        w_strb;
   logic        w_rd;
   logic        w_wr;
   logic [7:0]  w_byte;
   logic [3:0]  w_nib;
   logic        w_unused;

   assign w_unused = &{1'b0, A[15:7], D_IN[0]};

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_as_m  <= 1'b1;
         r_as_s  <= 1'b1;
         r_uds_m <= 1'b1;
         r_uds_s <= 1'b1;
      end else begin
         r_as_m  <= AS_n;
         r_as_s  <= r_as_m;
         r_uds_m <= UDS_n;
         r_uds_s <= r_uds_m;
      end
   end

   assign w_sel  = (A[23:16] == 8'hE8) && !CFGIN_n &&
                   (r_state == UNCONFIG);
   assign w_strb = !r_as_s && !r_uds_s;
   assign w_rd   = w_strb && RW_n && w_sel;
   assign w_wr   = w_strb && !RW_n && w_sel && r_arm;

   // Byte-wide ROM image; A[1] picks the nibble within the byte.
   always_comb begin
      w_byte = 8'hFF;
      case (A[6:2])
         5'h00:   w_byte = JP4 ? 8'hE0 : 8'hE7;
         5'h01:   w_byte = ~PRODUCT;
         5'h02:   w_byte = ~FLAGS;
         5'h04:   w_byte = ~MANUFACTURER[15:8];
         5'h05:   w_byte = ~MANUFACTURER[7:0];
         5'h06:   w_byte = ~SERIAL[31:24];
         5'h07:   w_byte = ~SERIAL[23:16];
         5'h08:   w_byte = ~SERIAL[15:8];
         5'h09:   w_byte = ~SERIAL[7:0];
         default: w_byte = 8'hFF;
      endcase
   end

   assign w_nib = A[1] ? w_byte[3:0] : w_byte[7:4];

   always_comb begin
      w_state_nx = r_state;
      w_base_ld  = 1'b0;
      unique case (1'b1)
         (r_state == UNCONFIG) && w_wr && (A[6:1] == 6'h24): begin
            w_state_nx = CONFIGURED;
            w_base_ld  = 1'b1;
         end
`ifdef AUTOCONFIG_SHUTUP_EN
         (r_state == UNCONFIG) && w_wr && (A[6:1] == 6'h26): begin
            w_state_nx = SHUTUP;
         end
`endif
         default: begin
            w_state_nx = r_state;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_state    <= UNCONFIG;
         r_base     <= 3'b000;
         r_ramcfg_n <= 1'b1;
         r_cfgout_n <= 1'b1;
      end else begin
         r_state    <= w_state_nx;
         if (w_base_ld)
            r_base  <= D_IN[3:1];
         r_ramcfg_n <= (w_state_nx != CONFIGURED);
         r_cfgout_n <= (w_state_nx == UNCONFIG);
      end
   end

   // One commit per strobe; re-armed only once AS is seen high again.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n)
         r_arm <= 1'b1;
      else if (r_as_s)
         r_arm <= 1'b1;
      else if (w_wr)
         r_arm <= 1'b0;
   end

   // Data latched at the start of the read and held until release.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_doe  <= 1'b0;
         r_dout <= 4'h0;
      end else begin
         r_doe <= w_rd;
         if (w_rd && !r_doe)
            r_dout <= w_nib;
      end
   end

   assign D_OE             = r_doe;
   assign D_OUT            = r_dout;
   assign BASE_RAM         = r_base;
   assign RAM_CONFIGURED_n = r_ramcfg_n;
   assign CFGOUT_n         = r_cfgout_n;

endmodule

// File: tb/tb_zorro2_autoconfig.sv
// Directed bench for zorro2_autoconfig: reads, writes, chain gating, reset.
// Expectations follow the default build unless AUTOCONFIG_SHUTUP_EN is set.
module tb_zorro2_autoconfig;

   logic        CLK = 1'b0;
   logic        RESET_n = 1'b0;
   logic [23:1] A = '0;
   logic        RW_n = 1'b1;
   logic        AS_n = 1'b1;
   logic        UDS_n = 1'b1;
   logic [3:0]  D_IN = 4'h0;
   logic [3:0]  D_OUT;
   logic        D_OE;
   logic        CFGIN_n = 1'b0;
   logic        CFGOUT_n;
   logic        JP4 = 1'b0;
   logic [2:0]  BASE_RAM;
   logic        RAM_CONFIGURED_n;

   int nchk = 0;
   int nfail = 0;

   always #5 CLK = ~CLK;

   zorro2_autoconfig #(
      .MANUFACTURER (16'h1234),
      .PRODUCT      (8'h5A),
      .SERIAL       (32'hCAFE0001)
   ) dut (
      .CLK              (CLK),
      .RESET_n          (RESET_n),
      .A                (A),
      .RW_n             (RW_n),
      .AS_n             (AS_n),
      .UDS_n            (UDS_n),
      .D_IN             (D_IN),
      .D_OUT            (D_OUT),
      .D_OE             (D_OE),
      .CFGIN_n          (CFGIN_n),
      .CFGOUT_n         (CFGOUT_n),
      .JP4              (JP4),
      .BASE_RAM         (BASE_RAM),
      .RAM_CONFIGURED_n (RAM_CONFIGURED_n)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [2:0] base,
                            input logic rcn, input logic con);
      chk({tag, "_base"}, {5'd0, BASE_RAM}, {5'd0, base});
      chk({tag, "_rcn"}, {7'd0, RAM_CONFIGURED_n}, {7'd0, rcn});
      chk({tag, "_cfgout"}, {7'd0, CFGOUT_n}, {7'd0, con});
   endtask

   task automatic bus_rd(input logic [23:0] addr, output logic [3:0] d,
                         output logic oe);
      logic [23:0] a;
      a = addr;
      A = a[23:1];
      RW_n = 1'b1;
      @(posedge CLK); #1;
      AS_n = 1'b0;
      UDS_n = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      d = D_OUT;
      oe = D_OE;
      AS_n = 1'b1;
      UDS_n = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
   endtask

   task automatic bus_wr(input logic [23:0] addr, input logic [3:0] d,
                         input int hold);
      logic [23:0] a;
      a = addr;
      A = a[23:1];
      RW_n = 1'b0;
      D_IN = d;
      @(posedge CLK); #1;
      AS_n = 1'b0;
      UDS_n = 1'b0;
      repeat (hold) @(posedge CLK);
      #1;
      AS_n = 1'b1;
      UDS_n = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      RW_n = 1'b1;
   endtask

   task automatic rd_chk(input string tag, input logic [23:0] addr,
                         input logic [3:0] exp);
      logic [3:0] d;
      logic oe;
      bus_rd(addr, d, oe);
      chk({tag, "_oe"}, {7'd0, oe}, 8'h01);
      chk(tag, {4'd0, d}, {4'd0, exp});
      chk({tag, "_release"}, {7'd0, D_OE}, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET_n = 1'b0;
      #2;
      RESET_n = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [3:0] d;
      logic oe;

      repeat (2) @(posedge CLK);
      #1;
      chk("rst_doe", {7'd0, D_OE}, 8'h00);
      chk("rst_dout", {4'd0, D_OUT}, 8'h00);
      chk_state("rst", 3'b000, 1'b1, 1'b1);
      RESET_n = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      JP4 = 1'b0;
      rd_chk("type4_hi", 24'hE80000, 4'hE);
      rd_chk("type4_lo", 24'hE80002, 4'h7);
      JP4 = 1'b1;
      rd_chk("type8_hi", 24'hE80000, 4'hE);
      rd_chk("type8_lo", 24'hE80002, 4'h0);
      JP4 = 1'b0;

      rd_chk("prod_hi", 24'hE80004, 4'hA);
      rd_chk("prod_lo", 24'hE80006, 4'h5);
      rd_chk("unused30", 24'hE80030, 4'hF);
      rd_chk("mfr_hi", 24'hE80010, 4'hE);
      rd_chk("mfr_hi_lo", 24'hE80012, 4'hD);
      rd_chk("mfr_lo_hi", 24'hE80014, 4'hC);
      rd_chk("ser_msb_hi", 24'hE80018, 4'h3);
`ifdef AUTOCONFIG_SHUTUP_EN
      rd_chk("flags_hi", 24'hE80008, 4'hF);
`else
      rd_chk("flags_hi", 24'hE80008, 4'hB);
`endif

      bus_rd(24'hE90000, d, oe);
      chk("wrong_page_oe", {7'd0, oe}, 8'h00);

      CFGIN_n = 1'b1;
      bus_rd(24'hE80000, d, oe);
      chk("cfgin_rd_oe", {7'd0, oe}, 8'h00);
      bus_wr(24'hE80048, 4'h4, 5);
      chk_state("cfgin_wr", 3'b000, 1'b1, 1'b1);
      CFGIN_n = 1'b0;

      A = 24'hE80000 >> 1;
      RW_n = 1'b1;
      @(posedge CLK); #1;
      AS_n = 1'b0;
      UDS_n = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk("mid_cfgin_pre", {7'd0, D_OE}, 8'h01);
      CFGIN_n = 1'b1;
      @(posedge CLK); #1;
      chk("mid_cfgin_post", {7'd0, D_OE}, 8'h00);
      AS_n = 1'b1;
      UDS_n = 1'b1;
      CFGIN_n = 1'b0;
      repeat (4) @(posedge CLK);
      #1;

      bus_wr(24'hE8004A, 4'hE, 5);
      chk_state("wr4a", 3'b000, 1'b1, 1'b1);

      bus_wr(24'hE8004C, 4'h0, 5);
`ifdef AUTOCONFIG_SHUTUP_EN
      chk_state("shutup", 3'b000, 1'b1, 1'b0);
      bus_rd(24'hE80000, d, oe);
      chk("shutup_rd_oe", {7'd0, oe}, 8'h00);
      do_reset();
      chk_state("shutup_rst", 3'b000, 1'b1, 1'b1);
`else
      chk_state("wr4c", 3'b000, 1'b1, 1'b1);
`endif

      A = 24'hE80048 >> 1;
      RW_n = 1'b0;
      D_IN = 4'h4;
      @(posedge CLK); #1;
      AS_n = 1'b0;
      UDS_n = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk_state("cfg_mid", 3'b010, 1'b0, 1'b0);
      D_IN = 4'hE;
      repeat (6) @(posedge CLK);
      #1;
      AS_n = 1'b1;
      UDS_n = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      RW_n = 1'b1;
      chk_state("cfg_done", 3'b010, 1'b0, 1'b0);

      bus_wr(24'hE80048, 4'hC, 5);
      chk_state("cfg_locked", 3'b010, 1'b0, 1'b0);
      bus_rd(24'hE80000, d, oe);
      chk("post_cfg_rd_oe", {7'd0, oe}, 8'h00);

      @(negedge CLK);
      #1;
      RESET_n = 1'b0;
      #1;
      chk_state("async_rst", 3'b000, 1'b1, 1'b1);
      RESET_n = 1'b1;
      repeat (3) @(posedge CLK);
      #1;

      A = 24'hE80004 >> 1;
      RW_n = 1'b1;
      AS_n = 1'b0;
      UDS_n = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk("rst_rd_pre_oe", {7'd0, D_OE}, 8'h01);
      chk("rst_rd_pre_d", {4'd0, D_OUT}, 8'h0A);
      #1;
      RESET_n = 1'b0;
      #1;
      chk("rst_rd_oe", {7'd0, D_OE}, 8'h00);
      chk("rst_rd_dout", {4'd0, D_OUT}, 8'h00);
      AS_n = 1'b1;
      UDS_n = 1'b1;
      #1;
      RESET_n = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      chk("rst_rd_after", {7'd0, D_OE}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
